// File: rtl/uart_rx_par_chk.sv
// UART receiver: start, DATA_WIDTH bits LSB-first, optional parity, one stop; 3-sample majority per bit.
// Strobes follow frame end by one cycle; there is no backpressure, so the consumer must take every strobe.
module uart_rx_par_chk #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RX_IN,
  input  logic [PRESC_WIDTH-1:0] Prescale,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  output logic [DATA_WIDTH-1:0]  P_DATA,
  output logic                   data_valid,
  output logic                   par_err,
  output logic                   stp_err
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [PRESC_WIDTH-1:0] P_ONE    = PRESC_WIDTH'(1);
  localparam logic [BW-1:0]          B_ONE    = BW'(1);
  localparam logic [BW-1:0]          LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state, state_nxt;
  logic [PRESC_WIDTH-1:0]  edge_cnt;
  logic [PRESC_WIDTH-1:0]  presc_m1;
  logic [PRESC_WIDTH-1:0]  half;
  logic [BW-1:0]           bit_cnt;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [2:0]              samp;
  logic                    par_mis;
  logic                    bit_val;
  logic                    edge_last;
  logic                    cnt_run;
  logic                    bit_clr;
  logic                    shift_en;
  logic                    par_chk;
  logic                    frame_end;
  logic                    frame_ok;

  assign presc_m1  = Prescale - P_ONE;
  assign half      = Prescale >> 1;
  // >= rather than == so a Prescale shrunk mid-frame still wraps instead of running to counter overflow
  assign edge_last = (edge_cnt >= presc_m1);
  assign bit_val   = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!RX_IN) state_nxt = START;
      START:  if (edge_last) state_nxt = bit_val ? IDLE : DATA;
      DATA:   if (edge_last && bit_cnt == LAST_BIT) state_nxt = PAR_EN ? PARITY : STOP;
      PARITY: if (edge_last) state_nxt = STOP;
      STOP:   if (edge_last) state_nxt = RX_IN ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_run   = (state != IDLE);
    bit_clr   = (state == START);
    shift_en  = (state == DATA) && edge_last;
    par_chk   = (state == PARITY) && edge_last;
    frame_end = (state == STOP) && edge_last;
    frame_ok  = frame_end && bit_val && !(PAR_EN && par_mis);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      samp       <= '0;
      par_mis    <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      edge_cnt <= (!cnt_run || edge_last) ? '0 : edge_cnt + P_ONE;

      if (cnt_run) begin
        if (edge_cnt == half - P_ONE) samp[0] <= RX_IN;
        if (edge_cnt == half)         samp[1] <= RX_IN;
        if (edge_cnt == half + P_ONE) samp[2] <= RX_IN;
      end

      if (bit_clr) begin
        bit_cnt <= '0;
        par_mis <= 1'b0;
      end else if (shift_en) begin
        shift_reg[bit_cnt] <= bit_val;
        bit_cnt            <= bit_cnt + B_ONE;
      end else if (par_chk) begin
        par_mis <= bit_val ^ (^shift_reg) ^ PAR_TYP;
      end

      data_valid <= frame_ok;
      par_err    <= frame_end && PAR_EN && par_mis;
      stp_err    <= frame_end && !bit_val;
      if (frame_ok) P_DATA <= shift_reg;
    end
  end

endmodule

// File: tb/tb_uart_rx_par_chk.sv
// Directed bench for uart_rx_par_chk: a frame-level model predicts every strobe and P_DATA per cycle.
module tb_uart_rx_par_chk;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx_par_chk #(.DATA_WIDTH(8), .PRESC_WIDTH(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    bit         dv;
    bit         pe;
    bit         se;
    logic [7:0] d;
  } ev_t;

  ev_t        ev_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] model_pdata = 8'h00;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         dv_cyc = 0;
  int         last_start = 0;
  int         pe_cnt = 0;
  int         se_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Per-cycle comparison against the frame-level model
  always @(negedge CLK) begin
    bit exp_dv, exp_pe, exp_se;
    exp_dv = 1'b0; exp_pe = 1'b0; exp_se = 1'b0;
    if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
      exp_dv = ev_q[0].dv;
      exp_pe = ev_q[0].pe;
      exp_se = ev_q[0].se;
      if (ev_q[0].dv) model_pdata = ev_q[0].d;
      void'(ev_q.pop_front());
    end
    chk("data_valid", data_valid, exp_dv);
    chk("par_err", par_err, exp_pe);
    chk("stp_err", stp_err, exp_se);
    chk("P_DATA", P_DATA, model_pdata);
  end

  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      if (data_valid) begin
        rx_q.push_back(P_DATA);
        dv_cyc = cyc;
      end
      if (par_err) pe_cnt++;
      if (stp_err) se_cnt++;
    end
  end

  task automatic drive_bit(input logic v, input int n);
    RX_IN = v;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  // glitch = line bit index (0 = start) whose middle sample point gets a one-cycle flip
  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit, input int glitch);
    logic [10:0] bits;
    int          n, p;
    ev_t         ev;
    p = int'(Prescale);
    n = PAR_EN ? 11 : 10;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    if (PAR_EN) begin
      bits[9]  = par_bit;
      bits[10] = stop_bit;
    end else begin
      bits[9]  = stop_bit;
    end
    ev.cyc = cyc + n * p + 1;
    ev.pe  = PAR_EN && (par_bit != ((^d) ^ PAR_TYP));
    ev.se  = !stop_bit;
    ev.dv  = !ev.pe && !ev.se;
    ev.d   = d;
    ev_q.push_back(ev);
    last_start = cyc;
    for (int i = 0; i < n; i++) begin
      if (i == glitch) begin
        drive_bit(bits[i], p / 2 + 1);
        drive_bit(~bits[i], 1);
        drive_bit(bits[i], p / 2 - 2);
      end else begin
        drive_bit(bits[i], p);
      end
    end
  endtask

  initial begin
    RST = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_pdata", P_DATA, 8'h00);
    chk("reset_dv", data_valid, 1'b0);
    chk("reset_pe", par_err, 1'b0);
    chk("reset_se", stp_err, 1'b0);
    RST = 1'b1;
    idle(4);

    // Prescale 8, even parity, good frame
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    idle(8);
    chk("t1_count", rx_q.size(), 1);
    chk("t1_data", rx_q[0], 8'hA5);
    chk("t1_latency", dv_cyc - last_start, 89);

    // Odd parity expected 1, sent 0
    PAR_TYP = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b1, -1);
    idle(8);
    chk("t2_pe_count", pe_cnt, 1);
    chk("t2_dv_count", rx_q.size(), 1);
    chk("t2_pdata_held", P_DATA, 8'hA5);

    // Prescale 16, no parity, stop bit low
    Prescale = 6'd16; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    send_frame(8'h81, 1'b0, 1'b0, -1);
    idle(20);
    chk("t3_se_count", se_cnt, 1);
    chk("t3_dv_count", rx_q.size(), 1);

    // False start then a good frame
    Prescale = 6'd8; PAR_EN = 1'b1;
    drive_bit(1'b0, 3);
    idle(24);
    send_frame(8'h55, 1'b0, 1'b1, -1);
    idle(10);
    chk("t4_dv_count", rx_q.size(), 2);
    chk("t4_data", rx_q[1], 8'h55);
    chk("t4_pe_count", pe_cnt, 1);
    chk("t4_se_count", se_cnt, 1);

    // Prescale 32, back-to-back, glitch on data bit 1 of the first frame
    Prescale = 6'd32; PAR_EN = 1'b0;
    send_frame(8'h12, 1'b0, 1'b1, 2);
    send_frame(8'h34, 1'b0, 1'b1, -1);
    idle(40);
    chk("t5_dv_count", rx_q.size(), 4);
    chk("t5_first", rx_q[2], 8'h12);
    chk("t5_second", rx_q[3], 8'h34);

    // Reset in the middle of a 0xFF frame
    Prescale = 6'd8;
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b1, 4);
    RST = 1'b0;
    ev_q.delete();
    model_pdata = 8'h00;
    #1;
    chk("t6_rst_pdata", P_DATA, 8'h00);
    chk("t6_rst_dv", data_valid, 1'b0);
    chk("t6_rst_pe", par_err, 1'b0);
    chk("t6_rst_se", stp_err, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    RST = 1'b1;
    idle(8);
    send_frame(8'h0F, 1'b0, 1'b1, -1);
    idle(10);
    chk("t6_dv_count", rx_q.size(), 5);
    chk("t6_data", rx_q[4], 8'h0F);
    chk("t6_pdata", P_DATA, 8'h0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_par_chk.md
Name: uart_rx_par_chk

Overview:
UART receiver for the UART_TX/RX link. It deserialises one frame: start bit, 8 data bits LSB-first, an optional parity bit, and one stop bit. Each bit is oversampled by a runtime prescale factor and decided by a 3-sample majority vote. The block checks parity using the same rule as the transmit-side parity calculator and flags parity/stop errors. Output is a parallel byte with a one-cycle valid strobe, for the system/register-file side.

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESC_WIDTH, 6, width of the Prescale input

Ports:
CLK  input  1  system clock (oversampling clock)
RST  input  1  asynchronous active-low reset
RX_IN  input  1  serial line, idle high (already synchronised upstream)
Prescale  input  PRESC_WIDTH  oversampling ratio; legal values 8, 16, 32
PAR_EN  input  1  1 = frame carries a parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
P_DATA  output  DATA_WIDTH  last correctly received byte
data_valid  output  1  one-cycle strobe: P_DATA updated with a good frame
par_err  output  1  one-cycle strobe: parity mismatch on the frame just ended
stp_err  output  1  one-cycle strobe: stop bit sampled low on the frame just ended

Behaviour:
- Reset: RST low asynchronously forces the FSM to IDLE and clears edge/bit counters, the shift register, P_DATA, data_valid, par_err and stp_err to 0. Reset mid-frame discards the partial frame.
- Counters:
  - edge_cnt runs 0..Prescale-1 within each bit period and wraps to 0 at Prescale-1.
  - bit_cnt indexes the data bits 0..DATA_WIDTH-1.
- Sampling: RX_IN is captured at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1. The bit value is the majority of the three samples, available from edge_cnt = Prescale/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when RX_IN = 0, go to START with edge_cnt = 0 on the next cycle.
  - START: at edge_cnt = Prescale-1, go to DATA if the sampled bit is 0. If the sampled bit is 1 (glitch), go to IDLE with no error strobe.
  - DATA: at edge_cnt = Prescale-1, shift the sampled bit into shift register position bit_cnt (LSB first). When bit_cnt = DATA_WIDTH-1, go to PARITY if PAR_EN = 1, else to STOP.
  - PARITY: expected parity = XOR of the 8 data bits when PAR_TYP = 0, or its inverse when PAR_TYP = 1. At edge_cnt = Prescale-1, latch mismatch = sampled bit != expected, then go to STOP.
  - STOP: at edge_cnt = Prescale-1, end the frame.
- Frame end (registered, outputs visible the next cycle):
  - stp_err = 1 if the stop sample was 0.
  - par_err = 1 if PAR_EN = 1 and a mismatch was latched.
  - data_valid = 1 and P_DATA loaded only if both errors are 0; otherwise P_DATA holds its previous value.
  - All strobes are exactly 1 cycle wide.
- Back-to-back frames: at frame end, if RX_IN = 0 the FSM goes directly to START (edge_cnt = 0); otherwise to IDLE.
- Frame length is (10 + PAR_EN) × Prescale cycles from the first low RX_IN cycle to frame end.
- Configuration: PAR_EN, PAR_TYP and Prescale are sampled continuously and must be static during a frame. Changing them mid-frame is unsupported; the FSM must still return to IDLE within one frame length.
- An illegal Prescale value is unsupported. The implementation must not lock up; edge_cnt wraps at Prescale-1.

Test Plan:
- Prescale=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0 and stop 1 -> data_valid for one cycle 89 cycles after the start edge (88-cycle frame + 1 registered cycle), P_DATA=0xA5, par_err=0, stp_err=0.
- Same setup, PAR_TYP=1, frame 0x3C sent with parity 0 (correct odd parity is 1) -> par_err=1 for one cycle, data_valid=0, P_DATA unchanged.
- Prescale=16, PAR_EN=0, frame 0x81 with stop bit driven 0 -> stp_err=1 for one cycle, no data_valid.
- RX_IN low for 3 cycles then high (Prescale=8) -> FSM returns to IDLE after the start bit period, no strobes; a following valid 0x55 frame is received correctly.
- Prescale=32, two back-to-back frames 0x12 and 0x34 with no idle gap -> two data_valid strobes, P_DATA 0x12 then 0x34; a single-cycle glitch at a mid-bit sample point does not change the decoded value.
- Assert RST during DATA of frame 0xFF -> all outputs 0 immediately; the next frame 0x0F decodes correctly.
